html_tokenizer: RTL
===================

// Module: html_tokenizer
// PURPOSE
//  Consumes the raw character stream from the HTML file reader and splits it into tokens:
//  text runs, open-tag names and close-tag names. Tokens leave one character per entry,
//  with start/end/type tags, through a small FIFO to the DOM builder downstream.
//  Throttles the reader through `pause`.
// PARAMETERS
//  CHAR_W        8   character width; must match `CHAR_BITES
//  FIFO_DEPTH    4   output FIFO entries; power of 2, >=4
//  MAX_NAME_LEN  16  tag-name chars kept; extra chars are dropped
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  in_valid   in   1       in_char is valid this cycle
//  in_char    in   CHAR_W  input character
//  in_last    in   1       level: reader has finished, no further chars
//  pause      out  1       upstream must hold; registered
//  out_valid  out  1       FIFO head valid
//  out_ready  in   1       consumer accepts head when out_valid&out_ready
//  out_char   out  CHAR_W  token character
//  out_type   out  2       0 TEXT, 1 OPEN_TAG, 2 CLOSE_TAG
//  out_start  out  1       first char of token
//  out_end    out  1       last char of token
//  done       out  1       sticky: input exhausted and FIFO drained
//  error      out  1       sticky: malformed markup, truncation, or overrun
// BEHAVIOUR
//  Reset: FSM=S_TEXT, FIFO empty, pending empty, pause=0, out_valid=0, done=0, error=0.
//  FSM (advances only on accepted in_valid):
//   S_TEXT:  '<' -> S_LT (ends text token); other chars are text.
//   S_LT:    letter -> S_NAME (OPEN); '/' -> S_CLOSE; else error=1, -> S_TEXT, char dropped.
//   S_CLOSE: letter -> S_NAME (CLOSE); else error=1, -> S_TEXT.
//   S_NAME:  letter/digit -> name char; space/tab/CR/LF/'/' -> S_ATTR; '>' -> S_TEXT.
//   S_ATTR:  all chars discarded until '>' -> S_TEXT. "/>" is treated as a plain open tag.
//  Tag names are lowercased ('A'..'Z' +32). Chars past MAX_NAME_LEN: dropped, error=1.
//  Pending register: one token char is held until the next char decides out_end.
//   The held char is written to the FIFO when the next token char arrives, or when the
//   token terminates (end=1).
//   Empty text runs between tags emit nothing.
//  Max one FIFO write per cycle. Latency: in_char to FIFO head is 2 cycles minimum.
//  pause = registered (fifo_count >= FIFO_DEPTH-1).
//  in_valid while pause=1: char dropped, error=1.
//  in_last=1 with no in_valid: pending is flushed with end=1. An unterminated tag sets
//   error=1 and is discarded. done rises once the FIFO is empty and stays high.
//  FIFO full and empty are never simultaneous. Simultaneous write and read at count=DEPTH
//   is legal and the count is unchanged.
//  Reset mid-stream clears every state immediately. No partial token survives.
// CONFIGURATION
//  HTML_WS_COLLAPSE_EN defined:
//   - In text, a run of space/tab/CR/LF emits one ' '.
//   - A text token made only of whitespace is suppressed.
//  HTML_WS_COLLAPSE_EN undefined: all text chars pass through verbatim.
// STRUCTURE
//  Shared package html_pkg:
//   - TOK_TEXT/TOK_OPEN/TOK_CLOSE encodings
//   - FSM state encodings
//   - CHAR_LT/GT/SLASH/SPACE constants
//   - is_letter / is_ws / to_lower functions
//  Sub-module html_token_fifo(clock, reset, wr, din, rd, dout, count): synchronous FIFO,
//   width CHAR_W+4.
// TESTING
//  "<p>Hi</p>", out_ready=1 ->
//   (OPEN,'p',s1,e1)
//   (TEXT,'H',s1,e0)
//   (TEXT,'i',s0,e1)
//   (CLOSE,'p',s1,e1)
//   then done=1, error=0.
//  "<DIV class=x>a" -> OPEN "div" (d start, v end); TEXT 'a' s1/e1 after in_last; attrs absent.
//  out_ready=0 while streaming "abcdef" -> pause=1 by FIFO count 3; no drops, error=0.
//   Release -> "abcdef" in order.
//  Tag name of 20 letters -> first 16 emitted, 16th has end=1, error=1.
//  "<3" -> error=1, no output. Reset asserted mid-tag -> outputs at reset values next edge.
//  "a   b" with HTML_WS_COLLAPSE_EN -> 'a',' ','b'; without it -> 5 chars verbatim.

Source files
------------

// File: rtl/html_pkg.sv
// Shared types, encodings and character helpers for the HTML tokenizer.
// HTML_WS_COLLAPSE_EN (optional) turns on whitespace collapsing in text runs.
`timescale 1ns/1ps

package html_pkg;

    localparam int unsigned CHAR_BITS = 8;

    // token type carried with every output character
    typedef enum logic [1:0] {
        TOK_TEXT  = 2'd0,
        TOK_OPEN  = 2'd1,
        TOK_CLOSE = 2'd2
    } tok_e;

    // tokenizer parse states
    typedef enum logic [2:0] {
        S_TEXT  = 3'd0,
        S_LT    = 3'd1,
        S_CLOSE = 3'd2,
        S_NAME  = 3'd3,
        S_ATTR  = 3'd4
    } state_e;

    localparam logic [CHAR_BITS-1:0] CHAR_LT    = 8'h3C;
    localparam logic [CHAR_BITS-1:0] CHAR_GT    = 8'h3E;
    localparam logic [CHAR_BITS-1:0] CHAR_SLASH = 8'h2F;
    localparam logic [CHAR_BITS-1:0] CHAR_SPACE = 8'h20;

    // one FIFO entry: character plus token tags
    typedef struct packed {
        logic [CHAR_BITS-1:0] ch;
        tok_e                 typ;
        logic                 first;
        logic                 last;
    } tok_t;

    function automatic logic is_upper(input logic [CHAR_BITS-1:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic logic is_letter(input logic [CHAR_BITS-1:0] c);
        return is_upper(c) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic is_digit(input logic [CHAR_BITS-1:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_ws(input logic [CHAR_BITS-1:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
    endfunction

    function automatic logic [CHAR_BITS-1:0] to_lower(input logic [CHAR_BITS-1:0] c);
        return is_upper(c) ? (c + CHAR_BITS'(32)) : c;
    endfunction

endpackage

// File: rtl/html_token_fifo.sv
// Synchronous FIFO for token entries; write while full is accepted only with a read.
`timescale 1ns/1ps

module html_token_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic [W-1:0]     din,
    input  logic             rd,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd && (count != '0);
    assign do_wr = wr && ((count != CNT_W'(DEPTH)) || do_rd);
    assign dout  = mem[rd_ptr];

    // storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/html_tokenizer.sv
// Splits an HTML character stream into text / open-tag / close-tag tokens.
// One token char is held in a pending register until the next char decides its end tag.
// Optional: define HTML_WS_COLLAPSE_EN to collapse whitespace runs in text.
`timescale 1ns/1ps

module html_tokenizer
    import html_pkg::*;
#(
    parameter int unsigned CHAR_W       = CHAR_BITS,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_NAME_LEN = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              pause,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic [1:0]        out_type,
    output logic              out_start,
    output logic              out_end,
    output logic              done,
    output logic              error
);

    localparam int unsigned ENT_W = $bits(tok_t);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_W = $clog2(MAX_NAME_LEN + 1);

    state_e           state_q, state_d;
    tok_t             pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [LEN_W-1:0] name_len_q, name_len_d;
    logic             error_q, error_d;
    logic             done_q, done_d;
    logic             pause_q, pause_d;
`ifdef HTML_WS_COLLAPSE_EN
    logic             ws_run_q, ws_run_d;
`endif

    logic             fifo_wr;
    logic             fifo_rd;
    logic             fifo_full;
    logic             wr_last;
    logic             accept;
    logic             drop_ws;
    tok_t             fifo_din;
    tok_t             fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic [CHAR_W-1:0] ch;

    assign ch        = in_char;
    assign accept    = in_valid && !pause_q;
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_rd   = out_valid && out_ready;
    assign fifo_din  = {pend_q.ch, pend_q.typ, pend_q.first, wr_last};

`ifdef HTML_WS_COLLAPSE_EN
    // a text token that is a lone collapsed space is whitespace-only
    assign drop_ws = (pend_q.typ == TOK_TEXT) && pend_q.first && (pend_q.ch == CHAR_SPACE);
`else
    assign drop_ws = 1'b0;
`endif

    assign pause     = pause_q;
    assign done      = done_q;
    assign error     = error_q;
    assign out_valid = (fifo_count != '0);
    assign out_char  = fifo_dout.ch;
    assign out_type  = fifo_dout.typ;
    assign out_start = fifo_dout.first;
    assign out_end   = fifo_dout.last;

    // state and pending registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_TEXT;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            name_len_q <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            pause_q    <= 1'b0;
`ifdef HTML_WS_COLLAPSE_EN
            ws_run_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            name_len_q <= name_len_d;
            error_q    <= error_d;
            done_q     <= done_d;
            pause_q    <= pause_d;
`ifdef HTML_WS_COLLAPSE_EN
            ws_run_q   <= ws_run_d;
`endif
        end
    end

    // next-state, pending update and FIFO write decision
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        name_len_d = name_len_q;
        error_d    = error_q;
        done_d     = done_q;
        pause_d    = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
        fifo_wr    = 1'b0;
        wr_last    = 1'b0;
`ifdef HTML_WS_COLLAPSE_EN
        ws_run_d   = ws_run_q;
`endif

        if (in_valid && pause_q) begin
            error_d = 1'b1;
        end

        if (accept) begin
            unique case (state_q)
                S_TEXT: begin
                    if (ch == CHAR_LT) begin
                        fifo_wr    = pend_vld_q && !drop_ws;
                        wr_last    = 1'b1;
                        pend_vld_d = 1'b0;
                        state_d    = S_LT;
`ifdef HTML_WS_COLLAPSE_EN
                        ws_run_d   = 1'b0;
`endif
                    end else begin
`ifdef HTML_WS_COLLAPSE_EN
                        if (!(is_ws(ch) && ws_run_q)) begin
                            fifo_wr    = pend_vld_q;
                            pend_d     = '{ch: (is_ws(ch) ? CHAR_SPACE : ch), typ: TOK_TEXT,
                                           first: !pend_vld_q, last: 1'b0};
                            pend_vld_d = 1'b1;
                            ws_run_d   = is_ws(ch);
                        end
`else
                        fifo_wr    = pend_vld_q;
                        pend_d     = '{ch: ch, typ: TOK_TEXT, first: !pend_vld_q, last: 1'b0};
                        pend_vld_d = 1'b1;
`endif
                    end
                end
                S_LT: begin
                    if (is_letter(ch)) begin
                        pend_d     = '{ch: to_lower(ch), typ: TOK_OPEN, first: 1'b1, last: 1'b0};
                        pend_vld_d = 1'b1;
                        name_len_d = LEN_W'(1);
                        state_d    = S_NAME;
                    end else if (ch == CHAR_SLASH) begin
                        state_d = S_CLOSE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_TEXT;
                    end
                end
                S_CLOSE: begin
                    if (is_letter(ch)) begin
                        pend_d     = '{ch: to_lower(ch), typ: TOK_CLOSE, first: 1'b1, last: 1'b0};
                        pend_vld_d = 1'b1;
                        name_len_d = LEN_W'(1);
                        state_d    = S_NAME;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_TEXT;
                    end
                end
                S_NAME: begin
                    if (is_letter(ch) || is_digit(ch)) begin
                        if (name_len_q == LEN_W'(MAX_NAME_LEN)) begin
                            error_d = 1'b1;
                        end else begin
                            fifo_wr    = pend_vld_q;
                            pend_d     = '{ch: to_lower(ch), typ: pend_q.typ, first: 1'b0, last: 1'b0};
                            name_len_d = name_len_q + 1'b1;
                        end
                    end else if (is_ws(ch) || (ch == CHAR_SLASH) || (ch == CHAR_GT)) begin
                        fifo_wr    = pend_vld_q;
                        wr_last    = 1'b1;
                        pend_vld_d = 1'b0;
                        state_d    = (ch == CHAR_GT) ? S_TEXT : S_ATTR;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                S_ATTR: begin
                    if (ch == CHAR_GT) begin
                        state_d = S_TEXT;
                    end
                end
                default: state_d = S_TEXT;
            endcase
        end else if (in_last && !in_valid) begin
            if (state_q != S_TEXT) begin
                error_d    = 1'b1;
                pend_vld_d = 1'b0;
                state_d    = S_TEXT;
            end else if (pend_vld_q) begin
                if (drop_ws) begin
                    pend_vld_d = 1'b0;
                end else if (!fifo_full || fifo_rd) begin
                    fifo_wr    = 1'b1;
                    wr_last    = 1'b1;
                    pend_vld_d = 1'b0;
                end
            end else if (fifo_count == '0) begin
                done_d = 1'b1;
            end
        end

        if (fifo_wr && fifo_full && !fifo_rd) begin
            error_d = 1'b1;
        end
    end

    html_token_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .wr    (fifo_wr),
        .din   (fifo_din),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule
